// File: rtl/sprite_jump_mover.sv
// Per-frame sprite motion engine: keyboard-driven horizontal motion with
// clamped X bounds, plus a GROUND/RISE/FALL jump FSM with gravity, a
// saturated fall speed and an edge-qualified jump re-arm.
//
// state  | meaning
// -------+-----------------------------------------------------------
// GROUND | resting on the floor, pos_y pinned to Y_GROUND, may jump
// RISE   | moving up, vel_y negative, gravity slowing the climb
// FALL   | moving down, vel_y >= 0, saturates at VMAX until landing
module sprite_jump_mover #(
    parameter int W        = 10,
    parameter int X_INIT   = 300,
    parameter int Y_GROUND = 368,
    parameter int X_MIN    = 2,
    parameter int X_MAX    = 637,
    parameter int Y_MIN    = 2,
    parameter int X_STEP   = 3,
    parameter int JUMP_V   = 8,
    parameter int GRAVITY  = 1,
    parameter int VMAX     = 8
) (
    input  logic         frame_clk,
    input  logic         Reset,
    input  logic [15:0]  keycode,
    output logic [W-1:0] pos_x,
    output logic [W-1:0] pos_y,
    output logic [W-1:0] vel_x,
    output logic [W-1:0] vel_y,
    output logic [1:0]   state,
    output logic         on_ground
);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } state_t;

    // Two guard bits so that position + velocity can neither wrap nor lose sign.
    localparam int SW = W + 2;

    localparam logic signed [SW-1:0] X_MIN_S    = SW'(X_MIN);
    localparam logic signed [SW-1:0] X_MAX_S    = SW'(X_MAX);
    localparam logic signed [SW-1:0] Y_MIN_S    = SW'(Y_MIN);
    localparam logic signed [SW-1:0] Y_GROUND_S = SW'(Y_GROUND);
    localparam logic signed [SW-1:0] GRAVITY_S  = SW'(GRAVITY);
    localparam logic signed [SW-1:0] VMAX_S     = SW'(VMAX);

    localparam logic [W-1:0] X_INIT_W   = W'(X_INIT);
    localparam logic [W-1:0] X_MIN_W    = W'(X_MIN);
    localparam logic [W-1:0] X_MAX_W    = W'(X_MAX);
    localparam logic [W-1:0] Y_MIN_W    = W'(Y_MIN);
    localparam logic [W-1:0] Y_GROUND_W = W'(Y_GROUND);
    localparam logic [W-1:0] VMAX_W     = W'(VMAX);
    localparam logic [W-1:0] STEP_POS_W = W'(X_STEP);
    localparam logic [W-1:0] STEP_NEG_W = W'(-X_STEP);
    localparam logic [W-1:0] JUMP_NEG_W = W'(-JUMP_V);

    state_t       state_q, state_d;
    logic [W-1:0] pos_x_q, pos_x_d;
    logic [W-1:0] pos_y_q, pos_y_d;
    logic [W-1:0] vel_x_q, vel_x_d;
    logic [W-1:0] vel_y_q, vel_y_d;
    logic         jump_armed_q, jump_armed_d;
    logic         on_ground_q, on_ground_d;

    logic key_jump, key_left, key_right;
    logic signed [SW-1:0] x_sum;
    logic signed [SW-1:0] y_sum;
    logic signed [SW-1:0] vy_inc;
    logic unused_keys;

    assign key_jump    = keycode[0];
    assign key_left    = keycode[2];
    assign key_right   = keycode[3];
    assign unused_keys = ^{keycode[15:4], keycode[1]};

    // Horizontal velocity from the keys and clamped X update; independent of jump state.
    always_comb begin
        vel_x_d = '0;
        if (key_left && !key_right) begin
            vel_x_d = STEP_NEG_W;
        end else if (key_right && !key_left) begin
            vel_x_d = STEP_POS_W;
        end
        x_sum = $signed({2'b00, pos_x_q}) + $signed({{2{vel_x_d[W-1]}}, vel_x_d});
        if (x_sum < X_MIN_S) begin
            pos_x_d = X_MIN_W;
        end else if (x_sum > X_MAX_S) begin
            pos_x_d = X_MAX_W;
        end else begin
            pos_x_d = x_sum[W-1:0];
        end
    end

    // Jump FSM next state, vertical position/velocity and re-arm logic.
    always_comb begin
        state_d      = state_q;
        pos_y_d      = pos_y_q;
        vel_y_d      = vel_y_q;
        jump_armed_d = jump_armed_q | ~key_jump;
        y_sum        = $signed({2'b00, pos_y_q}) + $signed({{2{vel_y_q[W-1]}}, vel_y_q});
        vy_inc       = $signed({{2{vel_y_q[W-1]}}, vel_y_q}) + GRAVITY_S;

        case (state_q)
            ST_GROUND: begin
                if (key_jump && jump_armed_q) begin
                    state_d      = ST_RISE;
                    vel_y_d      = JUMP_NEG_W;
                    jump_armed_d = 1'b0;
                end else begin
                    vel_y_d = '0;
                    pos_y_d = Y_GROUND_W;
                end
            end
            ST_RISE: begin
                if (y_sum < Y_MIN_S) begin
                    // Ceiling hit: stop dead and start falling.
                    pos_y_d = Y_MIN_W;
                    vel_y_d = '0;
                    state_d = ST_FALL;
                end else begin
                    pos_y_d = y_sum[W-1:0];
                    vel_y_d = vy_inc[W-1:0];
                    if (!vy_inc[SW-1]) begin
                        state_d = ST_FALL;
                    end
                end
            end
            ST_FALL: begin
                if (y_sum >= Y_GROUND_S) begin
                    pos_y_d = Y_GROUND_W;
                    vel_y_d = '0;
                    state_d = ST_GROUND;
                end else begin
                    pos_y_d = y_sum[W-1:0];
                    vel_y_d = (vy_inc > VMAX_S) ? VMAX_W : vy_inc[W-1:0];
                end
            end
            default: begin
                pos_y_d = Y_GROUND_W;
                vel_y_d = '0;
                state_d = ST_GROUND;
            end
        endcase

        on_ground_d = (state_d == ST_GROUND);
    end

    // State registers with synchronous reset that wins over any motion, even mid-air.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q      <= ST_GROUND;
            pos_x_q      <= X_INIT_W;
            pos_y_q      <= Y_GROUND_W;
            vel_x_q      <= '0;
            vel_y_q      <= '0;
            jump_armed_q <= 1'b1;
            on_ground_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            vel_x_q      <= vel_x_d;
            vel_y_q      <= vel_y_d;
            jump_armed_q <= jump_armed_d;
            on_ground_q  <= on_ground_d;
        end
    end

    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign vel_x     = vel_x_q;
    assign vel_y     = vel_y_q;
    assign state     = state_q;
    assign on_ground = on_ground_q;

endmodule
